// File: rtl/stpmtr_ctrl.sv
// Stepper-motor position controller: steps pos_o towards a clamped absolute target with dir setup,
// programmable pulse rate and abort. Optional end ramps with STPMTR_RAMP_EN.
module stpmtr_ctrl #(
  parameter int unsigned POS_W      = 8,
  parameter int unsigned POS_MAX    = 240,
  parameter int unsigned HALF_PER   = 1,
  parameter int unsigned DIR_SETUP  = 2,
  parameter int unsigned RAMP_STEPS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [POS_W-1:0] pos_i,
  input  logic             valid,
  input  logic             stop_i,
  output logic             ack,
  output logic             busy_o,
  output logic [POS_W-1:0] pos_o,
  output logic             dir,
  output logic             pulse
);

  localparam int unsigned SLOW_PER = 2 * HALF_PER;
  localparam int unsigned CNT_MAX  = (DIR_SETUP > SLOW_PER) ? DIR_SETUP : SLOW_PER;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX) + 1;
  localparam logic [POS_W-1:0] POS_LIM = POS_W'(POS_MAX);

  // Elaboration-time guard against parameter sets the datapath cannot represent.
  if (HALF_PER < 1 || DIR_SETUP < 1 || POS_MAX > (2**POS_W) - 1 || RAMP_STEPS > POS_MAX + 1)
  begin : g_param_err
    $error("stpmtr_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, ACK} state_t;

  state_t           state;
  logic [POS_W-1:0] tgt;
  logic [CNT_W-1:0] cnt;
  logic             stop_pend;
  logic [POS_W-1:0] tgt_c;
  logic [POS_W-1:0] pos_nxt_c;
  logic [CNT_W-1:0] half_len_c;

  assign tgt_c     = (pos_i > POS_LIM) ? POS_LIM : pos_i;
  assign pos_nxt_c = dir ? (pos_o - POS_W'(1)) : (pos_o + POS_W'(1));

`ifdef STPMTR_RAMP_EN
  logic [POS_W-1:0] step_idx;
  logic [POS_W-1:0] remain_c;

  // Slow half-periods for the first and last RAMP_STEPS steps of a move.
  assign remain_c   = dir ? (pos_o - tgt) : (tgt - pos_o);
  assign half_len_c = (32'(step_idx) < RAMP_STEPS || 32'(remain_c) <= RAMP_STEPS)
                      ? CNT_W'(SLOW_PER) : CNT_W'(HALF_PER);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      step_idx <= '0;
    end else if (state == IDLE && valid) begin
      step_idx <= '0;
    end else if (state == LOW && cnt == half_len_c - CNT_W'(1)) begin
      step_idx <= step_idx + POS_W'(1);
    end
  end
`else
  assign half_len_c = CNT_W'(HALF_PER);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ack       <= 1'b0;
      busy_o    <= 1'b0;
      pos_o     <= '0;
      dir       <= 1'b0;
      pulse     <= 1'b0;
      tgt       <= '0;
      cnt       <= '0;
      stop_pend <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            tgt       <= tgt_c;
            cnt       <= '0;
            stop_pend <= 1'b0;
            busy_o    <= 1'b1;
            if (tgt_c == pos_o) begin
              state <= ACK;
              ack   <= 1'b1;
            end else begin
              dir   <= (tgt_c < pos_o);
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          if (stop_i) begin
            state <= ACK;
            ack   <= 1'b1;
          end else if (cnt == CNT_W'(DIR_SETUP - 1)) begin
            cnt   <= '0;
            pulse <= 1'b1;
            state <= HIGH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HIGH: begin
          // An abort during the high phase still finishes this step.
          if (stop_i) stop_pend <= 1'b1;
          if (cnt == half_len_c - CNT_W'(1)) begin
            cnt   <= '0;
            pulse <= 1'b0;
            state <= LOW;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LOW: begin
          if (cnt == half_len_c - CNT_W'(1)) begin
            cnt   <= '0;
            pos_o <= pos_nxt_c;
            if (pos_nxt_c == tgt || stop_pend || stop_i) begin
              state <= ACK;
              ack   <= 1'b1;
            end else begin
              pulse <= 1'b1;
              state <= HIGH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ACK: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          pulse  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stpmtr_ctrl.sv
// Randomised self-checking bench for stpmtr_ctrl against a timeline model of each move.
module tb_stpmtr_ctrl;

  localparam int unsigned POS_W      = 8;
  localparam int unsigned POS_MAX    = 240;
  localparam int unsigned HALF_PER   = 1;
  localparam int unsigned DIR_SETUP  = 2;
  localparam int unsigned RAMP_STEPS = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [POS_W-1:0] pos_i = '0;
  logic             valid = 1'b0;
  logic             stop_i = 1'b0;
  logic             ack;
  logic             busy_o;
  logic [POS_W-1:0] pos_o;
  logic             dir;
  logic             pulse;

  int checks = 0;
  int errors = 0;
  int cur_pos = 0;
  int cur_dir = 0;

  stpmtr_ctrl #(
    .POS_W(POS_W), .POS_MAX(POS_MAX), .HALF_PER(HALF_PER),
    .DIR_SETUP(DIR_SETUP), .RAMP_STEPS(RAMP_STEPS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pos_i(pos_i), .valid(valid), .stop_i(stop_i),
    .ack(ack), .busy_o(busy_o), .pos_o(pos_o), .dir(dir), .pulse(pulse)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input int e_pulse, input int e_ack, input int e_busy,
                            input int e_pos, input int e_dir);
    check({tag, ".pulse"}, int'(pulse), e_pulse);
    check({tag, ".ack"}, int'(ack), e_ack);
    check({tag, ".busy"}, int'(busy_o), e_busy);
    check({tag, ".pos"}, int'(pos_o), e_pos);
    check({tag, ".dir"}, int'(dir), e_dir);
  endtask

  // Model: cycle t=0 follows the accepting edge; step k is high for hl[k] cycles from st[k],
  // then low for hl[k]; ack is high at cycle a, idle from a+1.
  task automatic run_cmd(input string tag, input int target, input int stop_at, input bit stop_idle);
    int tgt, n, ndir, a, done, acc, h, comp, e_pos, e_pul, sgn;
    int hl[$];
    int st[$];
    tgt  = (target > int'(POS_MAX)) ? int'(POS_MAX) : target;
    n    = (tgt > cur_pos) ? tgt - cur_pos : cur_pos - tgt;
    ndir = (n == 0) ? cur_dir : int'(tgt < cur_pos);
    sgn  = (tgt >= cur_pos) ? 1 : -1;
    acc  = int'(DIR_SETUP);
    for (int k = 0; k < n; k++) begin
      h = int'(HALF_PER);
`ifdef STPMTR_RAMP_EN
      if (k < int'(RAMP_STEPS) || (n - k) <= int'(RAMP_STEPS)) h = 2 * int'(HALF_PER);
`endif
      hl.push_back(h);
      st.push_back(acc);
      acc += 2 * h;
    end
    a    = (n == 0) ? 0 : acc;
    done = n;
    if (n > 0 && stop_at >= 0) begin
      if (stop_at < int'(DIR_SETUP)) begin
        a    = stop_at + 1;
        done = 0;
      end else begin
        for (int k = 0; k < n; k++) begin
          if (stop_at >= st[k] && stop_at < st[k] + 2 * hl[k]) begin
            a    = st[k] + 2 * hl[k];
            done = k + 1;
            break;
          end
        end
      end
    end
    @(negedge clk_i);
    pos_i  = POS_W'(target);
    valid  = 1'b1;
    stop_i = stop_idle;
    @(posedge clk_i);
    for (int t = 0; t <= a + 1; t++) begin
      @(negedge clk_i);
      comp = 0;
      e_pul = 0;
      for (int k = 0; k < done; k++) begin
        if (st[k] + 2 * hl[k] <= t) comp++;
        if (t < a && t >= st[k] && t < st[k] + hl[k]) e_pul = 1;
      end
      e_pos = cur_pos + sgn * comp;
      check_outs(tag, e_pul, int'(t == a), int'(t <= a), e_pos, ndir);
      stop_i = (t == stop_at && stop_at <= a);
      pos_i  = POS_W'($urandom_range(0, 255));
      if (t == a) valid = 1'b0;
    end
    stop_i  = 1'b0;
    cur_pos = cur_pos + sgn * done;
    cur_dir = ndir;
  endtask

  task automatic reset_mid_move();
    bit seen;
    seen = 1'b0;
    @(negedge clk_i);
    pos_i = POS_W'((cur_pos > 100) ? 0 : 200);
    valid = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (pulse) seen = 1'b1;
    end
    check("rst_mid.pulse_seen", int'(seen), 1);
    #1 rst_i = 1'b1;
    #1 check_outs("rst_mid", 0, 0, 0, 0, 0);
    valid = 1'b0;
    @(negedge clk_i);
    check_outs("rst_hold", 0, 0, 0, 0, 0);
    rst_i   = 1'b0;
    cur_pos = 0;
    cur_dir = 0;
  endtask

  initial begin
    int tg, sa;
    #1 rst_i = 1'b1;
    #2 check_outs("reset", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check_outs("reset_rel", 0, 0, 0, 0, 0);

    run_cmd("up5", 5, -1, 1'b0);
    run_cmd("down2", 2, -1, 1'b0);
    run_cmd("to238", 238, -1, 1'b0);
    run_cmd("clamp", 250, -1, 1'b0);
    run_cmd("back5", 5, -1, 1'b0);
    run_cmd("same5", 5, -1, 1'b0);
    run_cmd("to0", 0, -1, 1'b0);
    run_cmd("stop4", 10, int'(DIR_SETUP) + 6 * int'(HALF_PER), 1'b0);
    run_cmd("stop_setup", 20, 0, 1'b0);
    run_cmd("stop_low", 30, int'(DIR_SETUP) + int'(HALF_PER), 1'b1);
    run_cmd("idle_stop", 3, -1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      tg = ($urandom_range(0, 3) == 0) ? cur_pos : int'($urandom_range(0, 255));
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 14)) : -1;
      run_cmd("rand", tg, sa, 1'($urandom_range(0, 1)));
    end

    reset_mid_move();
    run_cmd("post_rst", 7, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
